// File: rtl/tiny_slot_mux_pkg.sv
// Shared types and helpers for tiny_slot_mux.
package tiny_slot_mux_pkg;

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Ceiling log2 with a floor of 1, so single-value ranges still get a bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/tiny_sync2.sv
// Two-flop synchroniser for single-bit asynchronous inputs.
module tiny_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tiny_slot_mux.sv
// Hosts N_SLOTS user designs behind one pad set; one slot active, chosen over a serial config port.
// Optional TINY_SLOT_MUX_READBACK_EN adds cfg_sdo_o (registered shift-register MSB) for daisy-chaining.
//   state    | meaning
//   ST_RESET | all slots held in reset, counting RST_CYCLES
//   ST_RUN   | selected slot released, divided enable ticking
module tiny_slot_mux
  import tiny_slot_mux_pkg::*;
#(
  parameter  int N_SLOTS    = 8,
  parameter  int IN_W       = 7,
  parameter  int OUT_W      = 8,
  parameter  int CLK_DIV    = 4,
  parameter  int RST_CYCLES = 16,
  localparam int SEL_W      = clog2(N_SLOTS)
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     cfg_sclk_i,
  input  logic                     cfg_sdat_i,
  input  logic                     cfg_load_i,
  input  logic [IN_W-1:0]          user_in_i,
  output logic [OUT_W-1:0]         user_out_o,
  output logic [N_SLOTS*IN_W-1:0]  slot_in_o,
  input  logic [N_SLOTS*OUT_W-1:0] slot_out_i,
  output logic [N_SLOTS-1:0]       slot_ena_o,
  output logic [N_SLOTS-1:0]       slot_rst_no,
  output logic [SEL_W-1:0]         sel_o,
  output logic                     busy_o,
  output logic                     cfg_err_o
`ifdef TINY_SLOT_MUX_READBACK_EN
  ,
  output logic                     cfg_sdo_o
`endif
);

  localparam int RST_CW = clog2(RST_CYCLES);
  localparam int DIV_CW = clog2(CLK_DIV);
  localparam logic [RST_CW-1:0] RST_LAST = RST_CW'(RST_CYCLES - 1);
  localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(CLK_DIV - 1);

  logic sclk_s, sdat_s, load_s;
  logic sclk_d, load_d;
  logic sclk_rise, load_rise, load_ok;

  tiny_sync2 u_sync_sclk (.clk(wb_clk_i), .rst_n(wb_rst_ni), .d(cfg_sclk_i), .q(sclk_s));
  tiny_sync2 u_sync_sdat (.clk(wb_clk_i), .rst_n(wb_rst_ni), .d(cfg_sdat_i), .q(sdat_s));
  tiny_sync2 u_sync_load (.clk(wb_clk_i), .rst_n(wb_rst_ni), .d(cfg_load_i), .q(load_s));

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sclk_d <= 1'b0;
      load_d <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      load_d <= load_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign load_rise = load_s & ~load_d;

  logic [SEL_W-1:0] shreg, sel;
  logic [SEL_W:0]   shreg_ext;
  logic [31:0]      shreg_val;
  logic             cfg_err;

  assign shreg_ext = {shreg, sdat_s};
  assign shreg_val = 32'(shreg);
  assign load_ok   = load_rise && (shreg_val < 32'(N_SLOTS));

  // A load commits the pre-shift shreg value since both use the current register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      shreg   <= '0;
      sel     <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (sclk_rise) shreg <= shreg_ext[SEL_W-1:0];
      if (load_ok) sel <= shreg;
      else if (load_rise) cfg_err <= 1'b1;
    end
  end

  state_t             state, state_next;
  logic [RST_CW-1:0]  rst_cnt, rst_cnt_next;
  logic [DIV_CW-1:0]  div_cnt, div_cnt_next;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= ST_RESET;
      rst_cnt <= '0;
      div_cnt <= '0;
    end else begin
      state   <= state_next;
      rst_cnt <= rst_cnt_next;
      div_cnt <= div_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    rst_cnt_next = rst_cnt;
    div_cnt_next = '0;
    case (state)
      ST_RESET: begin
        if (rst_cnt == RST_LAST) begin
          state_next   = ST_RUN;
          rst_cnt_next = '0;
        end else begin
          rst_cnt_next = rst_cnt + RST_CW'(1);
        end
      end
      ST_RUN: begin
        div_cnt_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_CW'(1);
      end
      default: state_next = ST_RESET;
    endcase
    // Any valid load, even of the current selection, restarts the reset window.
    if (load_ok) begin
      state_next   = ST_RESET;
      rst_cnt_next = '0;
      div_cnt_next = '0;
    end
  end

  logic                    run;
  logic [N_SLOTS-1:0]      sel_onehot;
  logic [N_SLOTS*IN_W-1:0] slot_in_next, slot_in_q;

  assign run         = (state == ST_RUN);
  assign sel_onehot  = N_SLOTS'(1) << sel;
  assign slot_rst_no = run ? sel_onehot : '0;
  assign slot_ena_o  = (run && div_cnt == DIV_LAST) ? sel_onehot : '0;
  assign busy_o      = ~run;
  assign sel_o       = sel;
  assign cfg_err_o   = cfg_err;

  always_comb begin
    slot_in_next = '0;
    slot_in_next[sel*IN_W +: IN_W] = user_in_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      slot_in_q  <= '0;
      user_out_o <= '0;
    end else if (run) begin
      slot_in_q  <= slot_in_next;
      user_out_o <= slot_out_i[sel*OUT_W +: OUT_W];
    end else begin
      slot_in_q  <= '0;
      user_out_o <= '0;
    end
  end

  // Gated so a slot never sees stale pad data while the mux is in its reset window.
  assign slot_in_o = run ? slot_in_q : '0;

`ifdef TINY_SLOT_MUX_READBACK_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) cfg_sdo_o <= 1'b0;
    else            cfg_sdo_o <= shreg[SEL_W-1];
  end
`endif

endmodule

// File: tb/tb_tiny_slot_mux.sv
// Scoreboard bench for tiny_slot_mux: stimulus queues expected RUN entries, a monitor checks them.
// Builds with or without TINY_SLOT_MUX_READBACK_EN.
module tb_tiny_slot_mux;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_sclk, cfg_sdat, cfg_load;
  logic [6:0]  user_in;
  logic [7:0]  user_out8, user_out6;
  logic [55:0] slot_in8;
  logic [41:0] slot_in6;
  logic [63:0] slot_out8;
  logic [7:0]  ena8, rstn8;
  logic [5:0]  ena6, rstn6;
  logic [2:0]  sel8, sel6;
  logic        busy8, busy6, err8, err6;
`ifdef TINY_SLOT_MUX_READBACK_EN
  logic        sdo8, sdo6;
`endif

  always #5 clk = ~clk;

  tiny_slot_mux #(.N_SLOTS(8), .IN_W(7), .OUT_W(8), .CLK_DIV(CLK_DIV), .RST_CYCLES(16)) u_dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .cfg_sclk_i(cfg_sclk), .cfg_sdat_i(cfg_sdat),
    .cfg_load_i(cfg_load), .user_in_i(user_in), .user_out_o(user_out8), .slot_in_o(slot_in8),
    .slot_out_i(slot_out8), .slot_ena_o(ena8), .slot_rst_no(rstn8), .sel_o(sel8),
    .busy_o(busy8), .cfg_err_o(err8)
`ifdef TINY_SLOT_MUX_READBACK_EN
    , .cfg_sdo_o(sdo8)
`endif
  );

  tiny_slot_mux #(.N_SLOTS(6), .IN_W(7), .OUT_W(8), .CLK_DIV(CLK_DIV), .RST_CYCLES(16)) u_dut6 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .cfg_sclk_i(cfg_sclk), .cfg_sdat_i(cfg_sdat),
    .cfg_load_i(cfg_load), .user_in_i(user_in), .user_out_o(user_out6), .slot_in_o(slot_in6),
    .slot_out_i(slot_out8[47:0]), .slot_ena_o(ena6), .slot_rst_no(rstn6), .sel_o(sel6),
    .busy_o(busy6), .cfg_err_o(err6)
`ifdef TINY_SLOT_MUX_READBACK_EN
    , .cfg_sdo_o(sdo6)
`endif
  );

  typedef struct {
    int sel;
    int len;
  } run_exp_t;

  run_exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: measures each busy window, pops the expected selection on RUN entry, checks ticks.
  int busy_cnt = 0;
  int run_cnt = 0;
  int cur_sel = 0;
  bit in_run = 0;
  always @(negedge clk) begin
    run_exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
      in_run   = 0;
    end else if (busy8) begin
      busy_cnt++;
      in_run = 0;
    end else begin
      if (busy_cnt > 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL run_entry unexpected sel %0d", sel8);
        end else begin
          e = exp_q.pop_front();
          chk("run_sel", 64'(sel8), 64'(e.sel));
          chk("run_rst_no", 64'(rstn8), 64'(8'(1) << e.sel));
          chk("busy_len", 64'(busy_cnt), 64'(e.len));
          cur_sel = e.sel;
        end
        busy_cnt = 0;
        run_cnt  = 0;
        in_run   = 1;
      end else if (in_run) begin
        run_cnt++;
      end
      if (in_run)
        chk("ena_tick", 64'(ena8),
            (run_cnt % CLK_DIV == CLK_DIV - 1) ? 64'(8'(1) << cur_sel) : 64'd0);
    end
  end

  task automatic cyc(input logic sclk, input logic sdat, input logic load);
    cfg_sclk = sclk;
    cfg_sdat = sdat;
    cfg_load = load;
    @(posedge clk);
    #1;
  endtask

  task automatic shift3(input logic [2:0] v);
    for (int i = 2; i >= 0; i--) begin
      cyc(1'b1, v[i], 1'b0);
      cyc(1'b0, v[i], 1'b0);
    end
  endtask

  task automatic pulse_load();
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_busy(input logic lvl, input int limit, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy8 !== lvl && n < limit);
    if (busy8 !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s timeout busy %0b want %0b", name, busy8, lvl);
    end
  endtask

  task automatic wait_run(input string name);
    wait_busy(1'b1, 8, name);
    wait_busy(1'b0, 40, name);
  endtask

  // Test 4 sequence: load 2, shift in 011 during RESET, load again eight cycles later.
  logic [2:0] seq4 [11] = '{3'b001, 3'b001, 3'b100, 3'b000, 3'b110, 3'b010,
                            3'b110, 3'b010, 3'b001, 3'b001, 3'b000};

  initial begin
    logic [55:0] e_in;
    rst_n = 1'b0;
    cfg_sclk = 1'b0;
    cfg_sdat = 1'b0;
    cfg_load = 1'b0;
    user_in = '0;
    for (int k = 0; k < 8; k++) slot_out8[k*8 +: 8] = 8'h10 + 8'(k);
    slot_out8[5*8 +: 8] = 8'hA5;
    #1;
    chk("rst_sel", 64'(sel8), 64'd0);
    chk("rst_busy", 64'(busy8), 64'd1);
    chk("rst_rst_no", 64'(rstn8), 64'd0);
    chk("rst_ena", 64'(ena8), 64'd0);
    chk("rst_slot_in", 64'(slot_in8), 64'd0);
    chk("rst_user_out", 64'(user_out8), 64'd0);
    chk("rst_err", 64'(err6), 64'd0);

    // 1: release, slot 0 runs after 16 cycles
    exp_q.push_back('{sel: 0, len: 16});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_busy(1'b0, 40, "t1_run");
    repeat (12) @(negedge clk);

    // 2: select 5, output registered one cycle after RUN entry
    shift3(3'b101);
    exp_q.push_back('{sel: 5, len: 16});
    pulse_load();
    wait_run("t2_run");
    chk("t2_user_out_first", 64'(user_out8), 64'd0);
    @(negedge clk);
    chk("t2_user_out", 64'(user_out8), 64'hA5);
    chk("t2_sel6", 64'(sel6), 64'd5);

    // 3: 7 is out of range for six slots only
    shift3(3'b111);
    exp_q.push_back('{sel: 7, len: 16});
    pulse_load();
    wait_busy(1'b1, 8, "t3_busy");
    chk("t3_err6", 64'(err6), 64'd1);
    chk("t3_sel6", 64'(sel6), 64'd5);
    chk("t3_busy6", 64'(busy6), 64'd0);
    chk("t3_err8", 64'(err8), 64'd0);
`ifdef TINY_SLOT_MUX_READBACK_EN
    chk("t3_sdo", 64'(sdo8), 64'd1);
`endif
    wait_busy(1'b0, 40, "t3_run");
    repeat (3) @(negedge clk);

    // 4: second load during RESET restarts the window
    shift3(3'b010);
    exp_q.push_back('{sel: 3, len: 24});
    for (int i = 0; i < 11; i++) cyc(seq4[i][2], seq4[i][1], seq4[i][0]);
    wait_busy(1'b0, 40, "t4_run");
    chk("t4_sel6", 64'(sel6), 64'd3);
    repeat (3) @(negedge clk);

    // 5: datapath for slot 2, then async reset mid-run
    shift3(3'b010);
    exp_q.push_back('{sel: 2, len: 16});
    pulse_load();
    wait_run("t5_run");
    user_in = 7'h55;
    @(negedge clk);
    e_in = '0;
    e_in[2*7 +: 7] = 7'h55;
    chk("t5_slot_in", 64'(slot_in8), 64'(e_in));
    chk("t5_user_out", 64'(user_out8), 64'h12);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_sel", 64'(sel8), 64'd0);
    chk("t5_rst_busy", 64'(busy8), 64'd1);
    chk("t5_rst_rst_no", 64'(rstn8), 64'd0);
    chk("t5_rst_ena", 64'(ena8), 64'd0);
    chk("t5_rst_slot_in", 64'(slot_in8), 64'd0);
    chk("t5_rst_user_out", 64'(user_out8), 64'd0);
    chk("t5_rst_err6", 64'(err6), 64'd0);
    user_in = '0;
    exp_q.push_back('{sel: 0, len: 16});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_busy(1'b0, 40, "t5_rerun");
    repeat (3) @(negedge clk);

    // 6: same-cycle shift and load commits the pre-shift value
    shift3(3'b001);
    exp_q.push_back('{sel: 1, len: 16});
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    wait_run("t6_run");
    exp_q.push_back('{sel: 3, len: 16});
    pulse_load();
    wait_run("t6_run2");
    chk("t6_sel6", 64'(sel6), 64'd3);

    repeat (10) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tiny_slot_mux.md
Name: tiny_slot_mux

Overview:
- Parametrised successor to the single fixed user-module hookup in the user project wrapper.
- Hosts N_SLOTS small user designs behind one set of pads. Exactly one slot is active at a time.
- The active slot is chosen over a 3-wire serial config port (shift, then load).
- On every selection change the block holds the slots in reset, then generates a divided clock enable, forwards the pad inputs to the active slot and registers that slot's outputs back to the pads.

Parameters:
- N_SLOTS, 8, number of hosted user slots (2..64).
- IN_W, 7, data input width per slot (pad inputs after clock/reset pins).
- OUT_W, 8, output width per slot.
- CLK_DIV, 4, wb_clk_i cycles per slot enable tick (>=1; 1 = every cycle).
- RST_CYCLES, 16, slot reset hold length in wb_clk_i cycles (>=1).
- SEL_W, localparam = clog2(N_SLOTS), selection width.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- cfg_sclk_i  in  1  serial config shift clock, asynchronous to wb_clk_i.
- cfg_sdat_i  in  1  serial config data, MSB first.
- cfg_load_i  in  1  commit strobe, rising edge, asynchronous.
- user_in_i  in  IN_W  pad inputs.
- user_out_o  out  OUT_W  registered outputs to pads.
- slot_in_o  out  N_SLOTS*IN_W  per-slot inputs; slot k occupies bits [k*IN_W +: IN_W].
- slot_out_i  in  N_SLOTS*OUT_W  per-slot outputs, same packing.
- slot_ena_o  out  N_SLOTS  one-hot clock-enable tick.
- slot_rst_no  out  N_SLOTS  per-slot active-low reset.
- sel_o  out  SEL_W  committed selection.
- busy_o  out  1  high while in RESET state.
- cfg_err_o  out  1  sticky: an out-of-range selection was loaded.

Behaviour:
- Config synchronisation:
  - cfg_sclk_i, cfg_sdat_i and cfg_load_i each pass through a 2-flop synchroniser.
  - Rising edges are detected on the synchronised sclk and load.
  - Input-to-action latency is 3 cycles.
- Shift register (SEL_W bits): on a synchronised sclk rising edge, shreg <= {shreg[SEL_W-2:0], sdat}.
- Load:
  - On a synchronised load rising edge, the shreg value as it was *before* any same-cycle shift is used.
  - If that value < N_SLOTS: sel <= value and the FSM enters RESET, even if the value equals the current sel.
  - Otherwise: sel is unchanged, cfg_err_o <= 1, and the FSM is unaffected.
  - cfg_err_o clears only on wb_rst_ni.
- FSM, 2 states:
  - RESET: all slot_rst_no = 0, slot_ena_o = 0, slot_in_o = 0, user_out_o <= 0, busy_o = 1. A counter counts RST_CYCLES cycles, then the FSM goes to RUN. A new valid load while in RESET restarts the counter with the new sel.
  - RUN: slot_rst_no[sel] = 1; all other slots stay at 0.
- Divider (RUN only):
  - Counter 0..CLK_DIV-1, cleared on entry to RUN.
  - slot_ena_o[sel] pulses for one cycle when the counter = CLK_DIV-1, then the counter wraps to 0.
  - The first tick comes CLK_DIV cycles after entering RUN.
- Datapath (RUN):
  - slot_in_o for sel <= user_in_i, registered (1-cycle latency). Non-selected slots get 0.
  - user_out_o <= slot_out_i[sel], registered (1-cycle latency).
- Reset values (wb_rst_ni low):
  - sel_o = 0, shreg = 0, cfg_err_o = 0.
  - user_out_o = 0, slot_in_o = 0, slot_ena_o = 0, slot_rst_no = all 0.
  - FSM = RESET with counter 0, busy_o = 1.
  - On release, slot 0 runs after RST_CYCLES.
- Reset asserted mid-operation forces all of the above immediately (asynchronous).

Optional Feature:
- Macro TINY_SLOT_MUX_READBACK_EN.
- Defined: adds output port cfg_sdo_o (1 bit) = shreg[SEL_W-1], registered. This allows daisy-chaining several muxes on one config bus.
- Undefined: the port is absent; shreg behaviour is identical.

Decomposition:
- Package tiny_slot_mux_pkg: FSM state enum {ST_RESET, ST_RUN}; a clog2 helper function.
- One sub-module, tiny_sync2: 2-flop synchroniser with async active-low reset, instantiated 3 times.
- All other logic lives in tiny_slot_mux.

Test Plan:
1. Release reset with N_SLOTS=8, CLK_DIV=4, RST_CYCLES=16 -> busy_o high for 16 cycles, then slot_rst_no=8'b0000_0001, and slot_ena_o[0] pulses every 4th cycle.
2. Shift 3'b101, pulse load -> sel_o=5, busy_o high for 16 cycles, then slot_rst_no=8'b0010_0000. With slot_out_i[5]=8'hA5, user_out_o=8'hA5 one cycle later.
3. Set N_SLOTS=6, shift 3'b111, load -> cfg_err_o=1, sel_o unchanged, no RESET entry.
4. Load 2, then load 3 eight cycles into RESET -> counter restarts; RUN is entered 16 cycles after the second load with sel_o=3.
5. In RUN with sel=2, drive user_in_i=7'h55 -> slot_in_o slot 2 = 7'h55 after 1 cycle; all other slots 0. Assert wb_rst_ni mid-run -> all outputs take reset values immediately.
6. Same-cycle synchronised sclk and load edges -> the committed value excludes the new bit. With TINY_SLOT_MUX_READBACK_EN, cfg_sdo_o tracks shreg MSB.
